// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port 1024x16 program/data memory between the
// core (requester 0) and the host loader (requester 1).
// The core has fixed priority. A starvation counter lets the host win a conflict
// after STARVE_LIMIT blocked cycles. A burst lock gives the host up to LOCK_MAX
// back-to-back grants.
// Optional feature: define MEM_ARB_STATS_EN to add the conflict_cnt and
// starve_cnt statistics outputs.
module mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       starve_cnt
`endif
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(STARVE_LIMIT);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MAX - 1);

  typedef enum logic {
    ARB,
    LOCKED
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic              core_rd_q;
  logic              host_rd_q;
  logic              lock_hold;
  logic              starve_hit;
  logic              core_win;
  logic              host_win;

  // Winner selection. A host that keeps host_lock high stays shielded while it holds the
  // burst; a request without host_lock falls back to normal arbitration.
  // Nothing is granted while rst is high, so a read issued under reset never returns data.
  always_comb begin
    lock_hold  = (state == LOCKED) && !(host_req && !host_lock);
    starve_hit = core_req && host_req && (wait_cnt == WAIT_SAT);
    core_win   = 1'b0;
    host_win   = 1'b0;
    if (!rst) begin
      if (lock_hold) begin
        host_win = host_req;
      end else if (host_req && (!core_req || starve_hit)) begin
        host_win = 1'b1;
      end else begin
        core_win = core_req;
      end
    end
  end

  // Steer the granted requester's access onto the memory port; the port idles at zero.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (core_win) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_we    = core_we;
    end else if (host_win) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
    end
  end

  assign core_gnt    = core_win;
  assign host_gnt    = host_win;
  assign core_rvalid = core_rd_q && !rst;
  assign host_rvalid = host_rd_q && !rst;
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

  // Arbitration FSM: tracks the burst lock, the host starvation count and read-return flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      wait_cnt  <= '0;
      lock_cnt  <= '0;
      core_rd_q <= 1'b0;
      host_rd_q <= 1'b0;
    end else begin
      core_rd_q <= core_win && !core_we;
      host_rd_q <= host_win && !host_we;

      if (host_win || !host_req) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_SAT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      case (state)
        ARB: begin
          if (host_win && host_lock && (LOCK_MAX > 1)) begin
            state    <= LOCKED;
            lock_cnt <= LOCK_W'(1);
          end
        end
        LOCKED: begin
          if (lock_hold && host_req) begin
            if (lock_cnt == LOCK_LAST) begin
              state    <= ARB;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= lock_cnt + LOCK_W'(1);
            end
          end else begin
            state    <= ARB;
            lock_cnt <= '0;
          end
        end
        default: begin
          state    <= ARB;
          lock_cnt <= '0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic starve_override;
  assign starve_override = host_win && starve_hit && !lock_hold;

  // Saturating statistics: cycles with both requesters active, and host wins forced by starvation.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      starve_cnt   <= '0;
    end else begin
      if (core_req && host_req && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (starve_override && (starve_cnt != 16'hFFFF)) begin
        starve_cnt <= starve_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 1024x16 program/data memory between two requesters.
- Requester 0 is the core. Requester 1 is a host loader: I2C program download or a waveform-table DMA.
- Fixed priority to the core, with an anti-starvation counter for the host and a host burst lock for multi-word transfers.
- Sits between both requesters and the memory macro, which has 1-cycle synchronous read latency.

Parameters:
- ADDR_W, 10, memory address width
- DATA_W, 16, memory data width
- STARVE_LIMIT, 4, consecutive blocked host cycles after which the host wins the next conflict
- LOCK_MAX, 8, maximum consecutive host grants under host_lock

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- core_req  in  1  core access request
- core_we  in  1  core write enable (1 = write)
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core access issued to memory this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_W  core read data
- host_req  in  1  host access request
- host_we  in  1  host write enable
- host_lock  in  1  host requests burst ownership
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access issued this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the address

Behaviour:
- Handshake: a requester holds req, we, addr and wdata stable until it sees gnt high.
  - gnt is combinational in the same cycle; one transfer per gnt cycle.
  - Dropping req before gnt is legal and issues nothing.
- Memory drive:
  - Granted requester's addr, wdata and we pass straight through to mem_addr, mem_wdata and mem_we.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - rvalid is registered: it is high exactly one cycle after a granted read (we=0) of that requester.
  - rdata = mem_rdata in that cycle, 0 otherwise.
  - Writes never produce rvalid.
- FSM states: ARB, LOCKED.
  - ARB, only core_req: core granted.
  - ARB, only host_req: host granted.
  - ARB, both request: core granted unless wait_cnt==STARVE_LIMIT, then host granted.
  - ARB, host granted with host_lock=1: go to LOCKED, lock_cnt=1.
  - LOCKED: host granted whenever host_req=1, and the core is never granted.
  - LOCKED, each host grant: lock_cnt++.
  - LOCKED, return to ARB when any of:
    - host_lock=0, or
    - host_req=0, or
    - a grant brings lock_cnt to LOCK_MAX (transition after that grant).
  - LOCKED, cycle with host_req=1 and host_lock=0: arbitrated as ARB in that same cycle, and the next state is ARB.
- wait_cnt (width clog2(STARVE_LIMIT+1)):
  - +1 each cycle with host_req && !host_gnt, saturating at STARVE_LIMIT.
  - Cleared on host_gnt or !host_req.
- Reset:
  - Gnt/rvalid outputs 0, rdata outputs 0.
  - mem_we 0, mem_addr 0, mem_wdata 0.
  - State ARB, wait_cnt 0, lock_cnt 0.
  - A read granted in the cycle rst is asserted produces no rvalid afterwards.
- Core gnt low means the core must stall; the core sequencer uses !core_gnt as its hold.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined:
  - Adds outputs conflict_cnt[15:0] (+1 each cycle both req high) and starve_cnt[15:0] (+1 each host win by starvation override).
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Core-only read addr 10'h005, mem holds 16'hBEEF -> core_gnt high cycle 0, core_rvalid high cycle 1 with core_rdata=16'hBEEF, host outputs 0.
- Host-only write addr 10'h3FF data 16'h1234 -> host_gnt, mem_we=1, mem_addr=10'h3FF, mem_wdata=16'h1234 same cycle; no rvalid.
- Core and host both held high continuously, STARVE_LIMIT=4 -> core granted 4 cycles, host granted on cycle 5, wait_cnt back to 0; pattern repeats every 5 cycles.
- Host lock burst with core requesting throughout, LOCK_MAX=8, host_lock high 20 cycles -> host granted 8 consecutive cycles, then core gets the next conflict.
- Host releases host_lock after 3 locked grants -> FSM returns to ARB and the core is granted on the next conflict.
- rst asserted in the cycle after a granted core read -> core_rvalid stays 0, all outputs 0, state ARB.
- With MEM_ARB_STATS_EN, 10 cycles of both requesting, STARVE_LIMIT=4 -> conflict_cnt=10, starve_cnt=2.
